simd_mac_sat_pipe: RTL and testbench

//  Pipelined, parametrised SIMD multiply-accumulate unit with saturation. Successor to the

---
 rtl/simd_mac_sat_pipe_if.sv | 39 +++
 rtl/simd_mac_sat_pipe.sv | 147 ++++++++++++++
 tb/tb_simd_mac_sat_pipe.sv | 390 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/simd_mac_sat_pipe_if.sv
// Operand/result handshake bundle for simd_mac_sat_pipe.
// sat_flag is present only when MAC_SAT_FLAG_EN is defined.
interface simd_mac_sat_pipe_if #(
  parameter int unsigned LANES      = 4,
  parameter int unsigned LANE_WIDTH = 32
);
  localparam int unsigned REG_WIDTH = LANES * LANE_WIDTH;

  logic                 in_valid;
  logic                 in_ready;
  logic [2:0]           ctrl;
  logic [REG_WIDTH-1:0] reg_rs1;
  logic [REG_WIDTH-1:0] reg_rs2;
  logic [REG_WIDTH-1:0] reg_rs3;
  logic                 out_valid;
  logic                 out_ready;
  logic [REG_WIDTH-1:0] reg_rd;
`ifdef MAC_SAT_FLAG_EN
  logic [LANES-1:0]     sat_flag;

  modport master (
    output in_valid, ctrl, reg_rs1, reg_rs2, reg_rs3, out_ready,
    input  in_ready, out_valid, reg_rd, sat_flag
  );
  modport slave (
    input  in_valid, ctrl, reg_rs1, reg_rs2, reg_rs3, out_ready,
    output in_ready, out_valid, reg_rd, sat_flag
  );
`else
  modport master (
    output in_valid, ctrl, reg_rs1, reg_rs2, reg_rs3, out_ready,
    input  in_ready, out_valid, reg_rd
  );
  modport slave (
    input  in_valid, ctrl, reg_rs1, reg_rs2, reg_rs3, out_ready,
    output in_ready, out_valid, reg_rd
  );
`endif
endinterface

// File: rtl/simd_mac_sat_pipe.sv
// 3-stage SIMD halfword multiply-accumulate with per-lane saturation and valid/ready flow.
// Optional per-lane saturation flags are enabled by defining MAC_SAT_FLAG_EN.
module simd_mac_sat_pipe #(
  parameter int unsigned LANES      = 4,
  parameter int unsigned LANE_WIDTH = 32
) (
  input logic                clk,
  input logic                rst,
  simd_mac_sat_pipe_if.slave bus_io
);
  localparam int unsigned LW        = LANE_WIDTH;
  localparam int unsigned HW        = LANE_WIDTH / 2;
  localparam int unsigned REG_WIDTH = LANES * LANE_WIDTH;

  logic                  s1_v_q, s2_v_q, s3_v_q;
  logic [1:0]            s1_ctrl_q, s2_ctrl_q;  // {unsigned, sub}
  logic [LANES*HW-1:0]   s1_a_q, s1_b_q, s1_a_d, s1_b_d;
  logic [REG_WIDTH-1:0]  s1_acc_q, s2_acc_q;
  logic [REG_WIDTH-1:0]  s2_prod_q, s2_prod_d;
  logic [REG_WIDTH-1:0]  rd_q, rd_d;
  logic                  s3_free, s2_adv, s2_free, s1_adv, s1_free, accept;
`ifdef MAC_SAT_FLAG_EN
  logic [LANES-1:0]      flag_q, flag_d;
`endif

  function automatic logic [LW-1:0] ext(input logic [HW-1:0] v, input logic uns);
    return {{HW{v[HW-1] & ~uns}}, v};
  endfunction

  // Two guard bits hold any product +/- accumulator without wrap in either mode.
  function automatic logic [LW+1:0] lane_sum(input logic [LW-1:0] prod,
                                             input logic [LW-1:0] acc,
                                             input logic [1:0]    c);
    logic [LW+1:0] p;
    logic [LW+1:0] a;
    p = {{2{prod[LW-1] & ~c[1]}}, prod};
    a = {{2{acc[LW-1] & ~c[1]}}, acc};
    return c[0] ? p - a : p + a;
  endfunction

  function automatic logic [LW-1:0] clamp(input logic [LW+1:0] s, input logic uns);
    if (uns) begin
      if (s[LW+1]) return '0;
      if (s[LW]) return '1;
      return s[LW-1:0];
    end
    if (s[LW+1:LW-1] == 3'b000 || s[LW+1:LW-1] == 3'b111) return s[LW-1:0];
    return s[LW+1] ? {1'b1, {(LW-1){1'b0}}} : {1'b0, {(LW-1){1'b1}}};
  endfunction

`ifdef MAC_SAT_FLAG_EN
  function automatic logic clamped(input logic [LW+1:0] s, input logic uns);
    if (uns) return s[LW+1] | s[LW];
    return ~(s[LW+1:LW-1] == 3'b000 || s[LW+1:LW-1] == 3'b111);
  endfunction
`endif

  assign s3_free         = ~s3_v_q | bus_io.out_ready;
  assign s2_adv          = s2_v_q & s3_free;
  assign s2_free         = ~s2_v_q | s2_adv;
  assign s1_adv          = s1_v_q & s2_free;
  assign s1_free         = ~s1_v_q | s1_adv;
  assign bus_io.in_ready = ~rst & s1_free;
  assign accept          = bus_io.in_valid & bus_io.in_ready;

  assign bus_io.out_valid = s3_v_q;
  assign bus_io.reg_rd    = rd_q;
`ifdef MAC_SAT_FLAG_EN
  assign bus_io.sat_flag  = flag_q;
`endif

  always_comb begin
    s1_a_d    = '0;
    s1_b_d    = '0;
    s2_prod_d = '0;
    rd_d      = '0;
    for (int g = 0; g < LANES; g++) begin
      if (bus_io.ctrl[0]) begin
        s1_a_d[g*HW +: HW] = bus_io.reg_rs2[g*LW + HW +: HW];
        s1_b_d[g*HW +: HW] = bus_io.reg_rs3[g*LW + HW +: HW];
      end else begin
        s1_a_d[g*HW +: HW] = bus_io.reg_rs2[g*LW +: HW];
        s1_b_d[g*HW +: HW] = bus_io.reg_rs3[g*LW +: HW];
      end
      s2_prod_d[g*LW +: LW] = ext(s1_a_q[g*HW +: HW], s1_ctrl_q[1]) *
                              ext(s1_b_q[g*HW +: HW], s1_ctrl_q[1]);
      rd_d[g*LW +: LW] = clamp(lane_sum(s2_prod_q[g*LW +: LW], s2_acc_q[g*LW +: LW],
                                        s2_ctrl_q), s2_ctrl_q[1]);
    end
  end

`ifdef MAC_SAT_FLAG_EN
  always_comb begin
    flag_d = '0;
    for (int g = 0; g < LANES; g++) begin
      flag_d[g] = clamped(lane_sum(s2_prod_q[g*LW +: LW], s2_acc_q[g*LW +: LW], s2_ctrl_q),
                          s2_ctrl_q[1]);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q    <= 1'b0;
      s2_v_q    <= 1'b0;
      s3_v_q    <= 1'b0;
      s1_ctrl_q <= '0;
      s2_ctrl_q <= '0;
      s1_a_q    <= '0;
      s1_b_q    <= '0;
      s1_acc_q  <= '0;
      s2_acc_q  <= '0;
      s2_prod_q <= '0;
      rd_q      <= '0;
`ifdef MAC_SAT_FLAG_EN
      flag_q    <= '0;
`endif
    end else begin
      if (accept) begin
        s1_v_q    <= 1'b1;
        s1_ctrl_q <= bus_io.ctrl[2:1];
        s1_a_q    <= s1_a_d;
        s1_b_q    <= s1_b_d;
        s1_acc_q  <= bus_io.reg_rs1;
      end else if (s1_adv) begin
        s1_v_q <= 1'b0;
      end
      if (s1_adv) begin
        s2_v_q    <= 1'b1;
        s2_ctrl_q <= s1_ctrl_q;
        s2_prod_q <= s2_prod_d;
        s2_acc_q  <= s1_acc_q;
      end else if (s2_adv) begin
        s2_v_q <= 1'b0;
      end
      if (s2_adv) begin
        s3_v_q <= 1'b1;
        rd_q   <= rd_d;
`ifdef MAC_SAT_FLAG_EN
        flag_q <= flag_d;
`endif
      end else if (bus_io.out_ready) begin
        s3_v_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_simd_mac_sat_pipe.sv
// Scoreboard bench for simd_mac_sat_pipe: directed saturation cases, streaming, stalls,
// random flow control and mid-flight reset.
module tb_simd_mac_sat_pipe;
  localparam int unsigned LANES = 4;
  localparam int unsigned LW    = 32;
  localparam int unsigned RW    = LANES * LW;

  typedef struct {
    logic [RW-1:0]    rd;
    logic [LANES-1:0] fl;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  exp_t exp_q[$];

  simd_mac_sat_pipe_if #(.LANES(LANES), .LANE_WIDTH(LW)) bus_if ();

  simd_mac_sat_pipe #(.LANES(LANES), .LANE_WIDTH(LW)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus_if)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, expected bench to finish");
    $fatal(1, "watchdog");
  end

  // Reference: integer arithmetic on sign/zero-extended values, then clamp to the lane range.
  function automatic exp_t model(input logic [2:0] c, input logic [RW-1:0] r1,
                                 input logic [RW-1:0] r2, input logic [RW-1:0] r3);
    exp_t        m;
    logic [15:0] a, b;
    logic [31:0] acc;
    longint      av, bv, cv, s, lo, hi;
    for (int g = 0; g < LANES; g++) begin
      if (c[0]) begin
        a = r2[g*32+16 +: 16];
        b = r3[g*32+16 +: 16];
      end else begin
        a = r2[g*32 +: 16];
        b = r3[g*32 +: 16];
      end
      acc = r1[g*32 +: 32];
      if (c[2]) begin
        av = longint'(a);
        bv = longint'(b);
        cv = longint'(acc);
        lo = 0;
        hi = (longint'(1) << 32) - 1;
      end else begin
        av = longint'($signed(a));
        bv = longint'($signed(b));
        cv = longint'($signed(acc));
        lo = -(longint'(1) << 31);
        hi = (longint'(1) << 31) - 1;
      end
      s = c[1] ? av * bv - cv : av * bv + cv;
      m.fl[g] = (s > hi) || (s < lo);
      if (s > hi) s = hi;
      else if (s < lo) s = lo;
      m.rd[g*32 +: 32] = s[31:0];
    end
    return m;
  endfunction

  // One clock: sample handshakes just after the negedge, push on accept, advance to next negedge.
  task automatic tick(input bit push_model, output logic acc, output logic got,
                      output logic [RW-1:0] rd, output logic [LANES-1:0] fl);
    #1;
    acc = bus_if.in_valid & bus_if.in_ready;
    got = bus_if.out_valid & bus_if.out_ready;
    rd  = bus_if.reg_rd;
`ifdef MAC_SAT_FLAG_EN
    fl  = bus_if.sat_flag;
`else
    fl  = '0;
`endif
    if (acc && push_model)
      exp_q.push_back(model(bus_if.ctrl, bus_if.reg_rs1, bus_if.reg_rs2, bus_if.reg_rs3));
    cyc++;
    @(negedge clk);
  endtask

  task automatic rand_beat();
    bus_if.ctrl    = 3'($urandom_range(0, 7));
    bus_if.reg_rs1 = {$urandom(), $urandom(), $urandom(), $urandom()};
    bus_if.reg_rs2 = {$urandom(), $urandom(), $urandom(), $urandom()};
    bus_if.reg_rs3 = {$urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  task automatic test_reset();
    rst              = 1'b1;
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b0;
    bus_if.ctrl      = '0;
    bus_if.reg_rs1   = '0;
    bus_if.reg_rs2   = '0;
    bus_if.reg_rs3   = '0;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if (bus_if.in_ready !== 1'b0) begin
      n_bad++; $display("FAIL reset_in_ready: got %b expected 0", bus_if.in_ready);
    end
    n_cmp++;
    if (bus_if.out_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_out_valid: got %b expected 0", bus_if.out_valid);
    end
    n_cmp++;
    if (bus_if.reg_rd !== '0) begin
      n_bad++; $display("FAIL reset_rd: got %h expected 0", bus_if.reg_rd);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if (bus_if.in_ready !== 1'b1) begin
      n_bad++; $display("FAIL release_in_ready: got %b expected 1", bus_if.in_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [2:0]  vc[8];
    logic [31:0] v1[8], v2[8], v3[8], ve[8];
    logic        vf[8];
    logic        acc, got;
    logic [RW-1:0]    rd;
    logic [LANES-1:0] fl;
    exp_t        e;
    int          i, rcv, guard;
    vc[0] = 3'b000; v1[0] = 32'h7FFF_FFFF; v2[0] = 32'h0000_7FFF; v3[0] = 32'h0000_7FFF;
    ve[0] = 32'h7FFF_FFFF; vf[0] = 1'b1;
    vc[1] = 3'b011; v1[1] = 32'h7FFF_FFFF; v2[1] = 32'h8000_0000; v3[1] = 32'h7FFF_0000;
    ve[1] = 32'h8000_0000; vf[1] = 1'b1;
    vc[2] = 3'b000; v1[2] = 32'h0000_000A; v2[2] = 32'h0000_0003; v3[2] = 32'h0000_FFFE;
    ve[2] = 32'h0000_0004; vf[2] = 1'b0;
    vc[3] = 3'b100; v1[3] = 32'h0002_0000; v2[3] = 32'h0000_FFFF; v3[3] = 32'h0000_FFFF;
    ve[3] = 32'hFFFF_FFFF; vf[3] = 1'b1;
    vc[4] = 3'b110; v1[4] = 32'h0000_000A; v2[4] = 32'h0000_0002; v3[4] = 32'h0000_0003;
    ve[4] = 32'h0000_0000; vf[4] = 1'b1;
    vc[5] = 3'b100; v1[5] = 32'h0001_FFFE; v2[5] = 32'h0000_FFFF; v3[5] = 32'h0000_FFFF;
    ve[5] = 32'hFFFF_FFFF; vf[5] = 1'b0;
    vc[6] = 3'b000; v1[6] = 32'h3FFF_FFFF; v2[6] = 32'h0000_8000; v3[6] = 32'h0000_8000;
    ve[6] = 32'h7FFF_FFFF; vf[6] = 1'b0;
    vc[7] = 3'b001; v1[7] = 32'hBFFF_8000; v2[7] = 32'h8000_1234; v3[7] = 32'h7FFF_5678;
    ve[7] = 32'h8000_0000; vf[7] = 1'b0;
    i = 0; rcv = 0; guard = 0;
    bus_if.out_ready = 1'b1;
    while (rcv < 8 && guard < 100) begin
      guard++;
      if (i < 8) begin
        bus_if.in_valid = 1'b1;
        bus_if.ctrl     = vc[i];
        bus_if.reg_rs1  = {LANES{v1[i]}};
        bus_if.reg_rs2  = {LANES{v2[i]}};
        bus_if.reg_rs3  = {LANES{v3[i]}};
      end else begin
        bus_if.in_valid = 1'b0;
      end
      tick(1'b0, acc, got, rd, fl);
      if (acc) begin
        e.rd = {LANES{ve[i]}};
        e.fl = {LANES{vf[i]}};
        exp_q.push_back(e);
        i++;
      end
      if (got) begin
        rcv++; n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++; $display("FAIL directed_extra: got rd=%h, no result expected", rd);
        end else begin
          e = exp_q.pop_front();
          if (rd !== e.rd) begin
            n_bad++; $display("FAIL directed_rd[%0d]: got %h expected %h", rcv - 1, rd, e.rd);
          end
`ifdef MAC_SAT_FLAG_EN
          n_cmp++;
          if (fl !== e.fl) begin
            n_bad++; $display("FAIL directed_flag[%0d]: got %b expected %b", rcv - 1, fl, e.fl);
          end
`endif
        end
      end
    end
    n_cmp++;
    if (rcv != 8) begin
      n_bad++; $display("FAIL directed_count: got %0d results expected 8", rcv);
    end
  endtask

  task automatic test_stream();
    logic          acc, got, have;
    logic [RW-1:0] rd, held;
    logic [LANES-1:0] fl;
    exp_t          e;
    int            sent, rcv, guard, t, first_acc, first_got, last_got, n_acc;
    sent = 0; rcv = 0; guard = 0; first_acc = -1; first_got = -1; last_got = -1;
    bus_if.out_ready = 1'b1;
    while (rcv < 8 && guard < 100) begin
      guard++;
      bus_if.in_valid = (sent < 8);
      rand_beat();
      t = cyc;
      tick(1'b1, acc, got, rd, fl);
      if (acc) begin
        if (sent == 0) first_acc = t;
        sent++;
      end
      if (got) begin
        if (rcv == 0) first_got = t;
        last_got = t;
        rcv++; n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++; $display("FAIL stream_extra: got rd=%h, no result expected", rd);
        end else begin
          e = exp_q.pop_front();
          if (rd !== e.rd) begin
            n_bad++; $display("FAIL stream_rd[%0d]: got %h expected %h", rcv - 1, rd, e.rd);
          end
        end
      end
    end
    n_cmp++;
    if (first_got - first_acc != 3) begin
      n_bad++; $display("FAIL stream_latency: got %0d cycles expected 3", first_got - first_acc);
    end
    n_cmp++;
    if (rcv != 8 || last_got - first_got != 7) begin
      n_bad++; $display("FAIL stream_rate: got %0d results over %0d cycles expected 8 over 7",
                        rcv, last_got - first_got);
    end
    // Downstream stalls for 10 cycles: pipe absorbs exactly three beats and freezes.
    bus_if.out_ready = 1'b0;
    n_acc = 0; have = 1'b0; held = '0;
    for (int k = 0; k < 10; k++) begin
      bus_if.in_valid = 1'b1;
      rand_beat();
      tick(1'b1, acc, got, rd, fl);
      if (acc) n_acc++;
      if (have) begin
        n_cmp++;
        if (bus_if.out_valid !== 1'b1 || bus_if.reg_rd !== held) begin
          n_bad++; $display("FAIL stall_hold: got valid=%b rd=%h expected valid=1 rd=%h",
                            bus_if.out_valid, bus_if.reg_rd, held);
        end
      end else if (bus_if.out_valid === 1'b1) begin
        have = 1'b1;
        held = bus_if.reg_rd;
      end
    end
    n_cmp++;
    if (n_acc != 3) begin
      n_bad++; $display("FAIL stall_accepts: got %0d expected 3", n_acc);
    end
    #1;
    n_cmp++;
    if (bus_if.in_ready !== 1'b0) begin
      n_bad++; $display("FAIL stall_in_ready: got %b expected 0", bus_if.in_ready);
    end
    @(negedge clk);
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b1;
    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      guard++;
      tick(1'b0, acc, got, rd, fl);
      if (got) begin
        n_cmp++;
        e = exp_q.pop_front();
        if (rd !== e.rd) begin
          n_bad++; $display("FAIL drain_rd: got %h expected %h", rd, e.rd);
        end
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++; $display("FAIL drain_count: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_random();
    logic          acc, got, stall;
    logic [RW-1:0] rd, rd_before;
    logic [LANES-1:0] fl;
    exp_t          e;
    int            sent, rcv, guard;
    sent = 0; rcv = 0; guard = 0;
    while (rcv < 1000 && guard < 20000) begin
      guard++;
      bus_if.in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
      bus_if.out_ready = ($urandom_range(0, 3) != 0);
      rand_beat();
      stall     = bus_if.out_valid & ~bus_if.out_ready;
      rd_before = bus_if.reg_rd;
      tick(1'b1, acc, got, rd, fl);
      if (acc) sent++;
      if (stall) begin
        n_cmp++;
        if (bus_if.out_valid !== 1'b1 || bus_if.reg_rd !== rd_before) begin
          n_bad++; $display("FAIL random_hold: got valid=%b rd=%h expected valid=1 rd=%h",
                            bus_if.out_valid, bus_if.reg_rd, rd_before);
        end
      end
      if (got) begin
        rcv++; n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++; $display("FAIL random_extra: got rd=%h, no result expected", rd);
        end else begin
          e = exp_q.pop_front();
          if (rd !== e.rd) begin
            n_bad++; $display("FAIL random_rd[%0d]: got %h expected %h", rcv - 1, rd, e.rd);
          end
`ifdef MAC_SAT_FLAG_EN
          n_cmp++;
          if (fl !== e.fl) begin
            n_bad++; $display("FAIL random_flag[%0d]: got %b expected %b", rcv - 1, fl, e.fl);
          end
`endif
        end
      end
    end
    n_cmp++;
    if (rcv != 1000 || exp_q.size() != 0) begin
      n_bad++; $display("FAIL random_count: got %0d results, %0d pending expected 1000, 0",
                        rcv, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset_midflight();
    logic          acc, got;
    logic [RW-1:0] rd;
    logic [LANES-1:0] fl;
    int            n_acc, stale;
    bus_if.out_ready = 1'b0;
    n_acc = 0;
    for (int k = 0; k < 3; k++) begin
      bus_if.in_valid = 1'b1;
      rand_beat();
      tick(1'b1, acc, got, rd, fl);
      if (acc) n_acc++;
    end
    n_cmp++;
    if (n_acc != 3) begin
      n_bad++; $display("FAIL midreset_fill: got %0d accepts expected 3", n_acc);
    end
    rst = 1'b1;
    tick(1'b0, acc, got, rd, fl);
    #1;
    n_cmp++;
    if (bus_if.out_valid !== 1'b0 || bus_if.reg_rd !== '0 || bus_if.in_ready !== 1'b0) begin
      n_bad++; $display("FAIL midreset_state: got valid=%b rd=%h in_ready=%b expected 0 0 0",
                        bus_if.out_valid, bus_if.reg_rd, bus_if.in_ready);
    end
    exp_q.delete();
    @(negedge clk);
    rst              = 1'b0;
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b1;
    stale = 0;
    for (int k = 0; k < 10; k++) begin
      tick(1'b0, acc, got, rd, fl);
      if (got) stale++;
    end
    n_cmp++;
    if (stale != 0) begin
      n_bad++; $display("FAIL midreset_stale: got %0d results expected 0", stale);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stream();
    test_random();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
